// File: rtl/xor_sweep_pkg.sv
// Shared types and constants for the XOR target sweeper.
// Optional locate mode is built when XOR_SWEEP_LOCATE_EN is defined.
package xor_sweep_pkg;

   localparam int PAT_W        = 5;
   localparam int NUM_PATTERNS = 32;

   localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DWELL,
      ST_LOCATE
   } sweep_state_e;

   function automatic logic parity(input logic [PAT_W-1:0] a);
      return ^a;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous target output.
// Both stages reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/xor_target_sweeper.sv
// Steps the XOR target through all input patterns and checks parity.
// Define XOR_SWEEP_LOCATE_EN to build the free-running locate mode.
module xor_target_sweeper
   import xor_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int DWELL_CYCLES  = 1024,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             mode,
   input  logic             q,
   output logic [PAT_W-1:0] a_out,
   output logic             osc_en,
   output logic             busy,
   output logic             done,
   output logic             fault_valid,
   input  logic             fault_ready,
   output logic [PAT_W-1:0] fault_pattern,
   output logic [CNT_W-1:0] fault_cycle,
   output logic [CNT_W-1:0] fault_count,
   output logic             overflow
);

   localparam int PH_MAX =
      (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int PH_W = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0] DWELL_LAST  = PH_W'(DWELL_CYCLES - 1);

   sweep_state_e     state_q;
   sweep_state_e     state_d;
   logic [PH_W-1:0]  phase_q;
   logic [PH_W-1:0]  phase_d;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] pat_d;
   logic             done_d;

   logic q_sync;
   logic go_sweep;
   logic go_locate;
   logic settle_end;
   logic dwell_end;
   logic last_pat;
   logic mismatch;
   logic rec_clear;
   logic rec_load;
   logic rec_drop;
   logic rec_accept;
   logic cnt_full;

   sync_2ff u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (q),
      .q      (q_sync)
   );

`ifdef XOR_SWEEP_LOCATE_EN
   assign go_locate = start & mode;
`else
   logic mode_unused;
   assign mode_unused = mode;
   assign go_locate   = 1'b0;
`endif

   assign go_sweep   = start & ~go_locate;
   assign settle_end = (phase_q == SETTLE_LAST);
   assign dwell_end  = (phase_q == DWELL_LAST);
   assign last_pat   = (pat_q == LAST_PAT);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pat_d   = pat_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pat_d   = '0;
            phase_d = '0;
            if (go_locate) begin
               state_d = ST_LOCATE;
            end else if (go_sweep) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_end) begin
               phase_d = '0;
               state_d = ST_DWELL;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_DWELL: begin
            if (dwell_end) begin
               phase_d = '0;
               pat_d   = pat_q + 1'b1;
               state_d = ST_SETTLE;
               if (last_pat) begin
                  done_d = 1'b1;
                  if (!loop) state_d = ST_IDLE;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_LOCATE: begin
            pat_d   = '0;
            phase_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // stop overrides everything, including a same-cycle start
      if (stop) begin
         state_d = ST_IDLE;
         phase_d = '0;
         pat_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         pat_q   <= '0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pat_q   <= pat_d;
         done    <= done_d;
      end
   end

   assign mismatch = (state_q == ST_DWELL) & (q_sync != parity(pat_q));

   assign rec_clear  = (state_q == ST_IDLE) & go_sweep & ~stop;
   assign rec_load   = mismatch & (~fault_valid | fault_ready);
   assign rec_drop   = mismatch & fault_valid & ~fault_ready;
   assign rec_accept = ~mismatch & fault_valid & fault_ready & ~rec_clear;
   assign cnt_full   = &fault_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fault_valid   <= 1'b0;
         fault_pattern <= '0;
         fault_cycle   <= '0;
         overflow      <= 1'b0;
      end else begin
         unique case (1'b1)
            rec_clear: begin
               fault_valid <= 1'b0;
               overflow    <= 1'b0;
            end
            rec_load: begin
               fault_valid   <= 1'b1;
               fault_pattern <= pat_q;
               fault_cycle   <= CNT_W'(phase_q);
            end
            rec_drop: begin
               overflow <= 1'b1;
            end
            rec_accept: begin
               fault_valid <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fault_count <= '0;
      end else if (rec_clear) begin
         fault_count <= '0;
      end else if (mismatch && !cnt_full) begin
         fault_count <= fault_count + 1'b1;
      end
   end

   assign a_out = pat_q;
   assign busy  = (state_q != ST_IDLE);

`ifdef XOR_SWEEP_LOCATE_EN
   assign osc_en = (state_q == ST_LOCATE);
`else
   assign osc_en = 1'b0;
`endif

endmodule

// File: tb/tb_xor_target_sweeper.sv
// Randomized self-checking bench for xor_target_sweeper.
// Reference model follows the sweep timeline as plain cycle arithmetic.
module tb_xor_target_sweeper;

   localparam int SET   = 3;
   localparam int DW    = 4;
   localparam int CW    = 16;
   localparam int PER   = SET + DW;
   localparam int SWEEP = 32 * PER;

`ifdef XOR_SWEEP_LOCATE_EN
   localparam bit LOC = 1'b1;
`else
   localparam bit LOC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic          stop;
   logic          loop;
   logic          mode;
   logic          q;
   logic          fault_ready;
   logic [4:0]    a_out;
   logic          osc_en;
   logic          busy;
   logic          done;
   logic          fault_valid;
   logic [4:0]    fault_pattern;
   logic [CW-1:0] fault_cycle;
   logic [CW-1:0] fault_count;
   logic          overflow;

   xor_target_sweeper #(
      .SETTLE_CYCLES (SET),
      .DWELL_CYCLES  (DW),
      .CNT_W         (CW)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .stop          (stop),
      .loop          (loop),
      .mode          (mode),
      .q             (q),
      .a_out         (a_out),
      .osc_en        (osc_en),
      .busy          (busy),
      .done          (done),
      .fault_valid   (fault_valid),
      .fault_ready   (fault_ready),
      .fault_pattern (fault_pattern),
      .fault_cycle   (fault_cycle),
      .fault_count   (fault_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   string scen   = "reset";

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got %0h want %0h", scen, tag, got, exp);
      end
   endtask

   // reference model state
   bit         m_run;
   bit         m_loc;
   int         m_t;
   bit         m_done;
   bit         m_valid;
   bit         m_ovf;
   int         m_pat;
   int         m_cyc;
   int         m_cnt;
   logic [3:0] inj [32];

   int ncyc;
   int busy_at;
   int done_at;
   bit busy_prev;

   task automatic model_reset();
      m_run   = 0;
      m_loc   = 0;
      m_t     = 0;
      m_done  = 0;
      m_valid = 0;
      m_ovf   = 0;
      m_pat   = 0;
      m_cyc   = 0;
      m_cnt   = 0;
   endtask

   // target output as seen two cycles later by the comparison
   function automatic logic q_for(input int t);
      int p;
      int k;
      logic [4:0] pv;
      if (!m_run || t >= SWEEP || (t % PER) < SET) return 1'b0;
      p  = t / PER;
      k  = (t % PER) - SET;
      pv = p[4:0];
      return (^pv) ^ inj[p][k];
   endfunction

   task automatic check_outputs();
      int exp_a;
      exp_a = m_run ? (m_t / PER) : 0;
      check("busy", {31'd0, busy}, {31'd0, m_run | m_loc});
      check("a_out", {27'd0, a_out}, exp_a);
      check("osc_en", {31'd0, osc_en}, {31'd0, m_loc});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("fault_valid", {31'd0, fault_valid}, {31'd0, m_valid});
      check("fault_pattern", {27'd0, fault_pattern}, m_pat);
      check("fault_cycle", {16'd0, fault_cycle}, m_cyc);
      check("fault_count", {16'd0, fault_count}, m_cnt);
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   // one clock: check at negedge, drive, advance model, wait next negedge
   task automatic cyc(input bit st, input bit sp, input bit rdy,
                      input bit md, input bit lp);
      bit mis;
      int k;
      check_outputs();
      if (busy && !busy_prev) busy_at = ncyc;
      if (done) done_at = ncyc;
      busy_prev   = busy;
      start       = st;
      stop        = sp;
      fault_ready = rdy;
      mode        = md;
      loop        = lp;
      q           = m_loc ? 1'($urandom % 2) : q_for(m_t + 2);
      mis = 1'b0;
      if (m_run && (m_t % PER) >= SET) begin
         k   = (m_t % PER) - SET;
         mis = inj[m_t / PER][k];
      end
      if (mis) begin
         if (m_cnt != 32'hFFFF) m_cnt++;
         if (!m_valid || rdy) begin
            m_valid = 1;
            m_pat   = m_t / PER;
            m_cyc   = (m_t % PER) - SET;
         end else begin
            m_ovf = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      m_done = 0;
      if (sp) begin
         m_run = 0;
         m_loc = 0;
      end else if (m_run) begin
         m_t++;
         if (m_t == SWEEP) begin
            m_done = 1;
            m_t    = 0;
            m_run  = lp;
         end
      end else if (!m_loc && st) begin
         if (LOC && md) begin
            m_loc = 1;
         end else begin
            m_run   = 1;
            m_t     = 0;
            m_cnt   = 0;
            m_ovf   = 0;
            m_valid = 0;
         end
      end
      ncyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit lp, input bit rnd_rdy);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, rnd_rdy ? ($urandom % 3 == 0) : 1'b0, 1'b0, lp);
   endtask

   task automatic clear_inj();
      for (int p = 0; p < 32; p++) inj[p] = 4'h0;
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      loop        = 1'b0;
      mode        = 1'b0;
      q           = 1'b0;
      fault_ready = 1'b0;
      ncyc        = 0;
      busy_prev   = 1'b0;
      clear_inj();
      model_reset();
      #1;
      check_outputs();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      run(3, 1'b0, 1'b0);

      scen = "clean";
      busy_at = -1;
      done_at = -1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run(SWEEP + 4, 1'b0, 1'b0);
      check("done_latency", done_at - busy_at, SWEEP);

      scen = "inject";
      inj[11] = 4'b0110;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run(SWEEP + 4, 1'b0, 1'b0);
      check("inj_pattern", {27'd0, fault_pattern}, 32'h0B);
      check("inj_cycle", {16'd0, fault_cycle}, 1);
      check("inj_count", {16'd0, fault_count}, 2);

      scen = "backpressure";
      clear_inj();
      inj[3] = 4'b0001;
      inj[9] = 4'b0100;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run(SWEEP + 4, 1'b0, 1'b0);
      check("bp_pattern", {27'd0, fault_pattern}, 3);
      check("bp_overflow", {31'd0, overflow}, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0);

      scen = "random_loop";
      for (int p = 0; p < 32; p++)
         inj[p] = ($urandom % 6 == 0) ? 4'($urandom) : 4'h0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run(2 * SWEEP, 1'b1, 1'b1);
      run(SWEEP + 4, 1'b0, 1'b1);

      scen = "stop";
      clear_inj();
      inj[5] = 4'b1000;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run(17 * PER + 4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0);
      check("stop_count", {16'd0, fault_count}, 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0);

      scen = "reset_mid";
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run(100, 1'b1, 1'b1);
      resetn = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      resetn = 1'b1;
      run(2, 1'b0, 1'b0);

      scen = "locate";
      clear_inj();
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run(20, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(4, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_target_sweeper.md
# xor_target_sweeper

Sequencer for the laser-fault-injection XOR target. Steps the 5-bit XOR input bus through all 32 patterns, holds each for a programmable settle and dwell window, and compares the target output against expected parity every dwell cycle. Mismatches are counted and the first one is reported through a valid/ready record. An optional locate mode runs the target's clock term so the gate can be found under the laser.

## Interface
Parameters:
- SETTLE_CYCLES, 8: cycles after each pattern change with comparison disabled; minimum 3.
- DWELL_CYCLES, 1024: comparison cycles per pattern; minimum 1.
- CNT_W, 16: width of fault_count and fault_cycle.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- stop  in  1  abort; returns to IDLE next cycle.
- loop  in  1  sampled at sweep end: 1 restarts the sweep, 0 goes IDLE.
- mode  in  1  sampled with start: 0 = sweep, 1 = locate.
- q  in  1  target XOR output (asynchronous to clk).
- a_out  out  5  drives target inputs a[4:0].
- osc_en  out  1  drives target clock-enable (MMCM resetn).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the end of each sweep.
- fault_valid  out  1  fault record valid.
- fault_ready  in  1  consumer accepts the record.
- fault_pattern  out  5  a_out value at the captured mismatch.
- fault_cycle  out  CNT_W  dwell index (0-based) of the captured mismatch.
- fault_count  out  CNT_W  mismatching dwell cycles; saturates at all-ones.
- overflow  out  1  sticky; a mismatch arrived while fault_valid was high.

## Operation
- States: IDLE, SETTLE, DWELL, LOCATE.
- IDLE: a_out=0, osc_en=0. start with mode=0 goes to SETTLE with a_out=0, and clears fault_count, overflow, fault_valid. start with mode=1 goes to LOCATE.
- SETTLE: runs SETTLE_CYCLES cycles, then DWELL.
- DWELL: runs DWELL_CYCLES cycles. Each cycle compares q_sync with XOR-reduce(a_out).
  - If a_out < 31: a_out increments and the state returns to SETTLE.
  - If a_out = 31: done pulses; a_out wraps to 0. With loop=1 the state goes to SETTLE, otherwise IDLE.
- q passes through a 2-flop synchronizer. A settle of at least 3 cycles guarantees q_sync reflects the current pattern.
- osc_en is 0 in every sweep state, which stops the clock term so the expected value is pure parity.
- Mismatch handling:
  - fault_count increments, saturating.
  - If fault_valid=0: fault_pattern=a_out and fault_cycle=dwell index are loaded, and fault_valid=1 from the next cycle.
  - If fault_valid=1 and fault_ready=0: the record is dropped and overflow is set.
  - If fault_valid=1 and fault_ready=1 in the same cycle: the old record is accepted, the new one is loaded, and fault_valid stays 1.
- Record handshake: fault_valid and its payload are held stable until fault_ready. Records persist into IDLE until accepted.
- LOCATE: osc_en=1, a_out=0, no comparison, runs until stop.
- stop in any state: IDLE next cycle, osc_en=0, a_out=0. Counters and the pending record are kept. stop wins over a simultaneous start. start while busy is ignored.

## Timing
- Reset values: a_out=0, osc_en=0, busy=0, done=0, fault_valid=0, fault_pattern=0, fault_cycle=0, fault_count=0, overflow=0, state IDLE.
- start sampled at edge N: busy=1 and SETTLE begin at N+1.
- Per pattern: SETTLE_CYCLES+DWELL_CYCLES cycles. Per sweep: 32×(SETTLE_CYCLES+DWELL_CYCLES) cycles.
- done is high during the cycle after the last dwell cycle of pattern 31.
- Mismatch-to-fault_valid latency: 1 cycle. q-to-comparison latency: 2 cycles (synchronizer).
- Reset asserted mid-run: all outputs return to their reset values immediately.

## Configuration
- XOR_SWEEP_LOCATE_EN defined: the LOCATE state exists and mode is honoured.
- Not defined: no LOCATE state, mode is ignored (start always begins a sweep), and osc_en is tied 0.

## Structure
- Package xor_sweep_pkg holds the state enum, PAT_W=5, and NUM_PATTERNS=32.
- Sub-module sync_2ff provides the q synchronizer (reset value 0).

## Test plan
Bench parameters for all scenarios: SETTLE_CYCLES=3, DWELL_CYCLES=4, CNT_W=16.
- Fault-free sweep: model q=^a_out with 1-cycle lag, start, loop=0 -> done pulses exactly 224 cycles after busy rises; fault_count=0, fault_valid=0, ends in IDLE.
- Injected fault: force q inverted for dwell cycles 1–2 of pattern 5'h0B -> fault_pattern=5'h0B, fault_cycle=1, fault_count=2, overflow=0.
- Backpressure: fault_ready=0, mismatches at patterns 3 and 9 -> record holds pattern 3, overflow=1. Pulse fault_ready -> fault_valid=0 next cycle.
- Stop and collisions: stop at pattern 17 -> IDLE next cycle with a_out=0 and fault_count kept. start+stop together in IDLE -> stays IDLE.
- Loop and reset: loop=1 -> a_out wraps 31->0, done pulses every 224 cycles. resetn low mid-sweep -> all outputs at reset values.
- Locate (macro on): start with mode=1 -> osc_en=1 from the next cycle, q ignored, fault_count stays 0. stop -> osc_en=0. Macro off: same stimulus runs a normal sweep.
